// File: rtl/macarray_pkg.sv
// Shared definitions for the MacArray front end: default array geometry,
// the ifmap feeder state encoding and a helper to pick one element out of a
// packed MAC_ROW-wide ifmap vector (element r at bits [r*W +: W]).
package macarray_pkg;

    localparam int MAC_ROW_DEF        = 16;
    localparam int IFMAP_BITWIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    // Element idx of a default-geometry packed ifmap vector.
    function automatic logic [IFMAP_BITWIDTH_DEF-1:0] vec_slice(
        input logic [MAC_ROW_DEF*IFMAP_BITWIDTH_DEF-1:0] vec,
        input int unsigned                                idx
    );
        return vec[idx*IFMAP_BITWIDTH_DEF +: IFMAP_BITWIDTH_DEF];
    endfunction

endpackage

// File: rtl/ifmap_skew_line.sv
// Purpose: DEPTH-stage shift register of {valid, data} giving one array row its skew.
// Latency: DEPTH cycles from vld_i/dat_i to vld_o/dat_o. Backpressure: none, always shifts.
// Ports: clk/rst (sync, active-high); vld_i/dat_i enter stage 0; vld_o/dat_o leave the last stage.
module ifmap_skew_line
    import macarray_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = IFMAP_BITWIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] dat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    // Data only moves along with a valid bit, so every stage (and the output)
    // holds the last real element while bubbles pass through.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            if (vld_i) begin
                dat_q[0] <= dat_i;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Purpose: accepts MAC_ROW-wide ifmap vectors, pulses ifmap_start_out and skews row r by r cycles.
// Latency: vector accepted at cycle a reaches row r at a+1+r; done_out at L+MAC_ROW+1 after last accept L.
// Backpressure: in_ready high only while streaming a tile, independent of in_valid.
// Ports: tile_start_in starts a tile from IDLE; in_valid/in_ready/in_last/in_data vector stream;
//        ifmap_start_out/ifmap_enable_out/ifmap_data_out to the array; busy_out/done_out status.
module ifmap_skew_feeder
    import macarray_pkg::*;
#(
    parameter int MAC_ROW        = MAC_ROW_DEF,
    parameter int IFMAP_BITWIDTH = IFMAP_BITWIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tile_start_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic [MAC_ROW*IFMAP_BITWIDTH-1:0] in_data,
    output logic                              ifmap_start_out,
    output logic [MAC_ROW-1:0]                ifmap_enable_out,
    output logic [MAC_ROW*IFMAP_BITWIDTH-1:0] ifmap_data_out,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int CNT_W = $clog2(MAC_ROW) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAC_ROW - 1);

    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             accept;

    assign in_ready = (state_q == STREAM);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // start_q rises together with the move to STREAM, so the pulse
                // covers exactly the first STREAM cycle.
                if (tile_start_in) begin
                    state_d = STREAM;
                    start_d = 1'b1;
                end
            end
            STREAM: begin
                if (accept && in_last) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // MAC_ROW drain cycles let the deepest row emit the final element.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign ifmap_start_out = start_q;
    assign done_out        = done_q;
    assign busy_out        = (state_q != IDLE);

    for (genvar r = 0; r < MAC_ROW; r++) begin : g_row
        logic                      row_vld;
        logic [IFMAP_BITWIDTH-1:0] row_dat;

        ifmap_skew_line #(
            .DEPTH (r + 1),
            .WIDTH (IFMAP_BITWIDTH)
        ) u_line (
            .clk   (clk),
            .rst   (rst),
            .vld_i (accept),
            .dat_i (in_data[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH]),
            .vld_o (row_vld),
            .dat_o (row_dat)
        );

        assign ifmap_enable_out[r]                                   = row_vld;
        assign ifmap_data_out[r*IFMAP_BITWIDTH +: IFMAP_BITWIDTH]    = row_dat;
    end

endmodule
